// File: rtl/sub64bit_serial.sv
// sub64bit_serial: multi-cycle bit-serial subtractor for the ALU subq/cmp path.
// It computes diff = a - b as a + ~b + 1. Each clock it resolves BITS_PER_CYCLE bits,
// starting from the LSB. It also produces the Y86-64 condition codes OF, ZF and SF.
// Optional feature: define SUB64_CF_EN to add the cf port (unsigned borrow out).
// The execute stage stalls while busy is high. Results hold until the next done pulse.
module sub64bit_serial #(
  parameter int WIDTH          = 64,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             of,
  output logic             zf,
  output logic             sf
`ifdef SUB64_CF_EN
  ,output logic            cf
`endif
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  // A chunk width that does not divide the operand would leave a partial last step.
  generate
    if ((WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_cfg
      $error("sub64bit_serial: BITS_PER_CYCLE must divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             of_q, of_d;
  logic             zf_q, zf_d;
  logic             sf_q, sf_d;
`ifdef SUB64_CF_EN
  logic             cf_q, cf_d;
`endif

  // A start request counts whenever the unit is not busy, so it is accepted in IDLE and in DONE.
  logic accept;
  logic last_step;
  assign accept    = start && (state_q != S_RUN);
  assign last_step = (state_q == S_RUN) && (cnt_q == CW'(N - 1));

  // Ripple-carry chunk adder over the low bits of the shift registers.
  // c_chain[BITS_PER_CYCLE-1] is the carry into the chunk MSB. On the last step that bit is the word MSB.
  logic [BITS_PER_CYCLE:0]   c_chain;
  logic [BITS_PER_CYCLE-1:0] sum_chunk;
  logic [WIDTH-1:0]          res_shifted;

  assign c_chain[0] = carry_q;
  generate
    for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_chunk
      assign sum_chunk[gi]   = a_sh_q[gi] ^ b_sh_q[gi] ^ c_chain[gi];
      assign c_chain[gi + 1] = (a_sh_q[gi] & b_sh_q[gi]) |
                               (a_sh_q[gi] & c_chain[gi]) |
                               (b_sh_q[gi] & c_chain[gi]);
    end
    // Result bits enter at the MSB end. After N steps the first chunk has reached bit 0.
    if (BITS_PER_CYCLE == WIDTH) begin : g_res_full
      assign res_shifted = sum_chunk;
    end else begin : g_res_shift
      assign res_shifted = {sum_chunk, res_sh_q[WIDTH-1:BITS_PER_CYCLE]};
    end
  endgenerate

  // Next-state logic: IDLE -> RUN on start, RUN -> DONE after N steps, DONE -> RUN or IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_step) state_d = S_DONE;
      S_DONE:  state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: load the operands on accept, step once per RUN cycle, and publish flags on the last step.
  always_comb begin
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    of_d     = of_q;
    zf_d     = zf_q;
    sf_d     = sf_q;
`ifdef SUB64_CF_EN
    cf_d     = cf_q;
`endif
    if (accept) begin
      // Subtraction is performed as addition of the inverted subtrahend plus a carry-in of 1.
      a_sh_d  = a;
      b_sh_d  = ~b;
      carry_d = 1'b1;
      cnt_d   = '0;
    end else if (state_q == S_RUN) begin
      a_sh_d   = a_sh_q >> BITS_PER_CYCLE;
      b_sh_d   = b_sh_q >> BITS_PER_CYCLE;
      res_sh_d = res_shifted;
      carry_d  = c_chain[BITS_PER_CYCLE];
      cnt_d    = cnt_q + CW'(1);
      if (last_step) begin
        diff_d = res_shifted;
        of_d   = c_chain[BITS_PER_CYCLE] ^ c_chain[BITS_PER_CYCLE-1];
        zf_d   = ~|res_shifted;
        sf_d   = res_shifted[WIDTH-1];
`ifdef SUB64_CF_EN
        // If there is no carry out of a + ~b + 1, then a < b as unsigned numbers.
        cf_d   = ~c_chain[BITS_PER_CYCLE];
`endif
      end
    end
  end

  // State and datapath registers. Reset aborts any operation in flight and clears the results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      of_q     <= 1'b0;
      zf_q     <= 1'b0;
      sf_q     <= 1'b0;
`ifdef SUB64_CF_EN
      cf_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      of_q     <= of_d;
      zf_q     <= zf_d;
      sf_q     <= sf_d;
`ifdef SUB64_CF_EN
      cf_q     <= cf_d;
`endif
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign diff = diff_q;
  assign of   = of_q;
  assign zf   = zf_q;
  assign sf   = sf_q;
`ifdef SUB64_CF_EN
  assign cf   = cf_q;
`endif

endmodule
